// File: rtl/core_control.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/mem/writeback
// sequencing with memory wait timeout, debug halt and cycle/retire counters.
module core_control #(
  parameter int OPCODE_W = 7,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32
) (
  input  logic                control_clock,
  input  logic                control_reset_n,
  input  logic [OPCODE_W-1:0] control_opcode,
  input  logic                control_imem_ready,
  input  logic                control_dmem_ready,
  input  logic                control_halt_req,
  output logic                control_imem_req,
  output logic                control_dmem_req,
  output logic                control_dmem_we,
  output logic                control_ir_we,
  output logic                control_rf_we,
  output logic                control_pc_we,
  output logic [2:0]          control_state,
  output logic                control_fault,
  output logic [CNT_W-1:0]    control_cycles,
  output logic [CNT_W-1:0]    control_retired
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5,
    FAULT     = 3'd6,
    UNUSED    = 3'd7
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic [6:0] op;
  logic       is_load;
  logic       is_store;
  logic       is_branch;
  logic       legal;
  logic       wait_last;

  assign op        = control_opcode[6:0];
  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_branch = (op == OP_BRANCH);
  assign wait_last = (wait_cnt == WAIT_LAST);

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      is_load, is_store, is_branch: legal = 1'b1;
      op == OP_OP, op == OP_OPIMM:  legal = 1'b1;
      op == OP_JAL, op == OP_JALR:  legal = 1'b1;
      op == OP_LUI, op == OP_AUIPC: legal = 1'b1;
      default:                      legal = 1'b0;
    endcase
  end

  always_comb begin
    control_imem_req = 1'b0;
    control_dmem_req = 1'b0;
    control_dmem_we  = 1'b0;
    control_ir_we    = 1'b0;
    control_rf_we    = 1'b0;
    control_pc_we    = 1'b0;
    case (state)
      FETCH: begin
        control_imem_req = 1'b1;
        control_ir_we    = control_imem_ready;
      end
      EXECUTE: control_pc_we = is_branch;
      MEM: begin
        control_dmem_req = 1'b1;
        control_dmem_we  = is_store;
        control_pc_we    = is_store & control_dmem_ready;
      end
      WRITEBACK: begin
        control_rf_we = 1'b1;
        control_pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // Ready beats the timeout when both land in the same cycle.
  always_comb begin
    nxt = FAULT;
    case (state)
      FETCH:
        if (control_imem_ready) nxt = DECODE;
        else if (wait_last)     nxt = FAULT;
        else                    nxt = FETCH;
      DECODE:
        if (!legal)                nxt = FAULT;
        else if (control_halt_req) nxt = HALT;
        else                       nxt = EXECUTE;
      EXECUTE:
        if (is_load || is_store) nxt = MEM;
        else if (is_branch)      nxt = FETCH;
        else                     nxt = WRITEBACK;
      MEM:
        if (control_dmem_ready) nxt = is_store ? FETCH : WRITEBACK;
        else if (wait_last)     nxt = FAULT;
        else                    nxt = MEM;
      WRITEBACK: nxt = FETCH;
      HALT:      nxt = control_halt_req ? HALT : EXECUTE;
      default:   nxt = FAULT;
    endcase
  end

  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      state           <= FETCH;
      control_fault   <= 1'b0;
      wait_cnt        <= 8'd0;
      control_cycles  <= '0;
      control_retired <= '0;
    end else begin
      state         <= nxt;
      control_fault <= control_fault | (nxt == FAULT);
      if (nxt != state)
        wait_cnt <= 8'd0;
      else if (state == FETCH || state == MEM)
        wait_cnt <= wait_cnt + 8'd1;
      if (state != HALT && state != FAULT)
        control_cycles <= control_cycles + CNT_W'(1);
      if (control_pc_we)
        control_retired <= control_retired + CNT_W'(1);
    end
  end

  assign control_state = state;

endmodule

// File: tb/tb_core_control.sv
// Directed bench for core_control: per-cycle vector table plus
// hand sequences for halt, timeout, illegal opcode and reset.
module tb_core_control;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] ILL    = 7'b1111111;

  typedef struct {
    logic [6:0] op;
    logic       imr;
    logic       dmr;
    logic [2:0] st;
    logic [6:0] outs;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        imem_ready;
  logic        dmem_ready;
  logic        halt_req;
  logic        imem_req, dmem_req, dmem_we;
  logic        ir_we, rf_we, pc_we;
  logic [2:0]  state;
  logic        fault;
  logic [31:0] cycles, retired;

  logic        imem_req4, dmem_req4, dmem_we4;
  logic        ir_we4, rf_we4, pc_we4;
  logic [2:0]  state4;
  logic        fault4;
  logic [3:0]  cycles4, retired4;

  int checks = 0;
  int fails  = 0;
  vec_t vecs[25];

  core_control dut (
    .control_clock      (clk),
    .control_reset_n    (rst_n),
    .control_opcode     (opcode),
    .control_imem_ready (imem_ready),
    .control_dmem_ready (dmem_ready),
    .control_halt_req   (halt_req),
    .control_imem_req   (imem_req),
    .control_dmem_req   (dmem_req),
    .control_dmem_we    (dmem_we),
    .control_ir_we      (ir_we),
    .control_rf_we      (rf_we),
    .control_pc_we      (pc_we),
    .control_state      (state),
    .control_fault      (fault),
    .control_cycles     (cycles),
    .control_retired    (retired)
  );

  core_control #(.CNT_W(4)) dut4 (
    .control_clock      (clk),
    .control_reset_n    (rst_n),
    .control_opcode     (opcode),
    .control_imem_ready (imem_ready),
    .control_dmem_ready (dmem_ready),
    .control_halt_req   (halt_req),
    .control_imem_req   (imem_req4),
    .control_dmem_req   (dmem_req4),
    .control_dmem_we    (dmem_we4),
    .control_ir_we      (ir_we4),
    .control_rf_we      (rf_we4),
    .control_pc_we      (pc_we4),
    .control_state      (state4),
    .control_fault      (fault4),
    .control_cycles     (cycles4),
    .control_retired    (retired4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic [6:0] o, logic i, logic d,
                              logic [2:0] s, logic [6:0] x);
    vec_t v;
    v.op = o; v.imr = i; v.dmr = d; v.st = s; v.outs = x;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // outs order: imem_req dmem_req dmem_we ir_we rf_we pc_we fault
  task automatic chk_out(string name, logic [2:0] s, logic [6:0] x);
    @(negedge clk);
    chk(name,
        {22'd0, state, imem_req, dmem_req, dmem_we,
         ir_we, rf_we, pc_we, fault},
        {22'd0, s, x});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(OPIMM,  1, 0, 0, 7'b1001000);
    vecs[1]  = mk(OPIMM,  1, 0, 1, 7'b0000000);
    vecs[2]  = mk(OPIMM,  1, 0, 2, 7'b0000000);
    vecs[3]  = mk(OPIMM,  1, 0, 4, 7'b0000110);
    vecs[4]  = mk(LOAD,   1, 0, 0, 7'b1001000);
    vecs[5]  = mk(LOAD,   1, 0, 1, 7'b0000000);
    vecs[6]  = mk(LOAD,   0, 0, 2, 7'b0000000);
    vecs[7]  = mk(LOAD,   0, 0, 3, 7'b0100000);
    vecs[8]  = mk(LOAD,   0, 0, 3, 7'b0100000);
    vecs[9]  = mk(LOAD,   0, 0, 3, 7'b0100000);
    vecs[10] = mk(LOAD,   0, 1, 3, 7'b0100000);
    vecs[11] = mk(LOAD,   0, 0, 4, 7'b0000110);
    vecs[12] = mk(STORE,  1, 0, 0, 7'b1001000);
    vecs[13] = mk(STORE,  0, 0, 1, 7'b0000000);
    vecs[14] = mk(STORE,  0, 0, 2, 7'b0000000);
    vecs[15] = mk(STORE,  0, 1, 3, 7'b0110010);
    vecs[16] = mk(BRANCH, 1, 0, 0, 7'b1001000);
    vecs[17] = mk(BRANCH, 0, 0, 1, 7'b0000000);
    vecs[18] = mk(BRANCH, 0, 0, 2, 7'b0000010);
    vecs[19] = mk(JAL,    1, 0, 0, 7'b1001000);
    vecs[20] = mk(JAL,    0, 0, 1, 7'b0000000);
    vecs[21] = mk(JAL,    0, 0, 2, 7'b0000000);
    vecs[22] = mk(JAL,    0, 0, 4, 7'b0000110);
    vecs[23] = mk(OP,     0, 0, 0, 7'b1000000);
    vecs[24] = mk(OP,     1, 0, 0, 7'b1001000);

    rst_n = 1'b0; opcode = OPIMM;
    imem_ready = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
    tick();
    chk_out("reset_outs", 3'd0, 7'b1000000);
    chk("reset_cycles", cycles, 32'd0);
    chk("reset_retired", retired, 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      opcode     = vecs[i].op;
      imem_ready = vecs[i].imr;
      dmem_ready = vecs[i].dmr;
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].outs);
      tick();
      chk($sformatf("cyc%0d", i), cycles, 32'(i + 1));
      chk($sformatf("cyc4_%0d", i), {28'd0, cycles4}, 32'((i + 1) % 16));
    end
    chk("retired_tbl", retired, 32'd5);
    chk("retired4_tbl", {28'd0, retired4}, 32'd5);

    imem_ready = 1'b0; opcode = OP; halt_req = 1'b1;
    chk_out("halt_dec", 3'd1, 7'b0000000);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("halt%0d", k), 3'd5, 7'b0000000);
      chk($sformatf("halt_cyc%0d", k), cycles, 32'd26);
      tick();
    end
    halt_req = 1'b0;
    chk_out("halt_rel", 3'd5, 7'b0000000);
    tick();
    chk_out("halt_exec", 3'd2, 7'b0000000);
    chk("halt_cyc_frozen", cycles, 32'd26);
    tick();
    chk_out("halt_wb", 3'd4, 7'b0000110);
    tick();
    chk("halt_retired", retired, 32'd6);

    opcode = LUI; imem_ready = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    imem_ready = 1'b1;
    chk_out("to_ready16", 3'd0, 7'b1001000);
    tick();
    imem_ready = 1'b0;
    chk_out("to_nofault", 3'd1, 7'b0000000);
    tick(); tick(); tick();
    for (int k = 0; k < 15; k++) tick();
    chk_out("to_wait16", 3'd0, 7'b1000000);
    tick();
    chk_out("to_fault", 3'd6, 7'b0000001);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    tick();
    chk_out("fault_sticky", 3'd6, 7'b0000001);

    imem_ready = 1'b0; dmem_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    chk_out("rst2_outs", 3'd0, 7'b1000000);
    chk("rst2_cycles", cycles, 32'd0);
    chk("rst2_retired", retired, 32'd0);
    rst_n = 1'b1;
    tick();

    opcode = ILL; halt_req = 1'b1; imem_ready = 1'b1;
    chk_out("ill_fetch", 3'd0, 7'b1001000);
    tick();
    chk_out("ill_dec", 3'd1, 7'b0000000);
    tick();
    chk_out("ill_fault", 3'd6, 7'b0000001);
    halt_req = 1'b0;
    tick(); tick();
    chk_out("ill_hold", 3'd6, 7'b0000001);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("ill_reset", 3'd0, 7'b1001000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/core_control.md
CORE_CONTROL -- requirements
Module: core_control

Interface
REQ-001 SHALL have parameter OPCODE_W, default 7: opcode field width; opcode values are compared on bits [6:0].
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum memory wait cycles before a fault; legal range 2..255.
REQ-003 SHALL have parameter CNT_W, default 32: width of the cycle and retire counters.
REQ-004 SHALL have port control_clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port control_reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port control_opcode, input, OPCODE_W bits: opcode of the instruction register.
REQ-007 SHALL have port control_imem_ready, input, 1 bit: instruction memory data valid.
REQ-008 SHALL have port control_dmem_ready, input, 1 bit: data memory access complete.
REQ-009 SHALL have port control_halt_req, input, 1 bit: level-sensitive debug halt request.
REQ-010 SHALL have port control_imem_req, output, 1 bit: instruction fetch request.
REQ-011 SHALL have port control_dmem_req, output, 1 bit: data access request.
REQ-012 SHALL have port control_dmem_we, output, 1 bit: data write enable, qualifies dmem_req.
REQ-013 SHALL have port control_ir_we, output, 1 bit: instruction register load strobe.
REQ-014 SHALL have port control_rf_we, output, 1 bit: register file write strobe.
REQ-015 SHALL have port control_pc_we, output, 1 bit: PC update strobe; marks instruction retire.
REQ-016 SHALL have port control_state, output, 3 bits: current state encoding.
REQ-017 SHALL have port control_fault, output, 1 bit: sticky fault flag.
REQ-018 SHALL have port control_cycles, output, CNT_W bits: active cycle counter.
REQ-019 SHALL have port control_retired, output, CNT_W bits: retired instruction counter.

Function
REQ-020 SHALL use these state encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, FAULT=6; 7 is unreachable and any occurrence SHALL go to FAULT.
REQ-021 SHALL recognise these opcodes: LOAD 0000011, STORE 0100011, OP 0110011, OP-IMM 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; every other opcode is illegal.
REQ-022 FETCH: imem_req=1; on imem_ready the block SHALL assert ir_we that same cycle and move to DECODE, otherwise stay in FETCH.
REQ-023 DECODE (1 cycle): illegal opcode goes to FAULT; otherwise halt_req=1 goes to HALT; otherwise the block goes to EXECUTE; illegal opcode takes priority over halt.
REQ-024 EXECUTE (1 cycle): LOAD/STORE go to MEM; BRANCH asserts pc_we and goes to FETCH; all other legal opcodes go to WRITEBACK.
REQ-025 MEM: dmem_req=1, with dmem_we=1 only for STORE; on dmem_ready, LOAD goes to WRITEBACK and STORE asserts pc_we and goes to FETCH.
REQ-026 WRITEBACK (1 cycle): rf_we=1 and pc_we=1, then FETCH.
REQ-027 HALT: all request and strobe outputs SHALL be 0; on halt_req=0 the block re-enters EXECUTE with the held instruction.
REQ-028 FAULT: all request and strobe outputs SHALL be 0, fault=1; the block leaves FAULT only by reset.
REQ-029 Request and strobe outputs SHALL be combinational from state, opcode and ready; they are 0 in any state not listed for them.
REQ-030 Wait counter: cleared on entering FETCH or MEM; increments each FETCH/MEM cycle with ready=0.
REQ-031 When ready=0 and the wait counter equals TIMEOUT-1, the block SHALL go to FAULT next cycle, so the fault is raised after TIMEOUT wait cycles.
REQ-032 If ready=1 arrives in the same cycle the wait counter reaches TIMEOUT-1, ready SHALL win and no fault is raised.
REQ-033 control_cycles SHALL increment every cycle the state is not HALT or FAULT, wrapping modulo 2^CNT_W.
REQ-034 control_retired SHALL increment on every cycle with pc_we=1, wrapping modulo 2^CNT_W.

Reset
REQ-035 With control_reset_n=0 at a rising edge, the following SHALL hold next cycle: state=FETCH, fault=0, cycles=0, retired=0, wait counter=0.
REQ-036 Reset SHALL take priority over every transition, including mid-wait and FAULT.
REQ-037 During and after reset, imem_req SHALL follow the FETCH state (1); all other request and strobe outputs SHALL be 0.

Verification
REQ-038 OP-IMM, imem_ready high from the first FETCH cycle -> states 0,1,2,4,0; rf_we and pc_we in cycle 4; retired=1 after 4 cycles.
REQ-039 LOAD with dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1 and dmem_we=0; then WRITEBACK; retired +1.
REQ-040 STORE -> MEM with dmem_we=1; on ready, pc_we=1, rf_we never asserted, next state FETCH.
REQ-041 imem_ready low for 16 cycles (TIMEOUT=16) -> fault=1 and state=6; ready asserted exactly on wait cycle 16 -> no fault.
REQ-042 Illegal opcode 1111111 with halt_req=1 -> FAULT, not HALT; fault persists until reset_n=0 for one edge, then state=0.
REQ-043 halt_req held 5 cycles at DECODE -> HALT, cycles counter frozen; on release -> EXECUTE; counter wrap checked with CNT_W=4 (15 -> 0).
